// File: rtl/inst_queue_param.sv
// Fetch-to-decode instruction queue: compacts masked fetch slots into a
// circular buffer and exposes the oldest ISSUE_W entries to decode.
module inst_queue_param #(
  parameter int FETCH_W     = 4,
  parameter int ISSUE_W     = 2,
  parameter int DEPTH       = 16,
  parameter int ENTRY_W     = 72,
  parameter int STOP_THRESH = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         enq_valid_i,
  output logic                         enq_ready_o,
  input  logic [FETCH_W-1:0]           enq_mask_i,
  input  logic [31:0]                  enq_pc_i,
  input  logic [FETCH_W*ENTRY_W-1:0]   enq_data_i,
  input  logic [$clog2(ISSUE_W+1)-1:0] deq_num_i,
  output logic [ISSUE_W-1:0]           out_valid_o,
  output logic [ISSUE_W*32-1:0]        out_pc_o,
  output logic [ISSUE_W*ENTRY_W-1:0]   out_data_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         stop_fetch_o,
  output logic                         drop_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LIM_P  = PW'(DEPTH - FETCH_W);
  localparam logic [PW-1:0] STOP_P = PW'(STOP_THRESH);
  localparam logic [PW-1:0] ISS_P  = PW'(ISSUE_W);
  localparam logic [PW-1:0] FULL_P = PW'(DEPTH);
  // PC bits that index a slot within the aligned fetch block
  localparam logic [31:0] PCM = 32'((FETCH_W * 4 - 1) & ~3);

  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [PW-1:0]      count;
  logic [PW-1:0]      req;
  logic [PW-1:0]      avail;
  logic [PW-1:0]      deq_n;
  logic               accept;
  logic [PW-1:0]      off   [FETCH_W+1];
  logic [AW-1:0]      waddr [FETCH_W];
  logic [31:0]        spc   [FETCH_W];
  logic [ENTRY_W-1:0] data_q [DEPTH];
  logic [31:0]        pc_q   [DEPTH];

  assign count        = tail_q - head_q;
  assign enq_ready_o  = (count <= LIM_P);
  assign accept       = enq_valid_i && enq_ready_o && !flush_i;
  assign count_o      = count;
  assign empty_o      = (count == '0);
  assign full_o       = (count == FULL_P);
  assign stop_fetch_o = (count >= STOP_P) && !flush_i;
  assign drop_err_o   = enq_valid_i && !enq_ready_o && !flush_i;

  assign req   = PW'(deq_num_i);
  assign avail = (count < ISS_P) ? count : ISS_P;
  assign deq_n = (req < avail) ? req : avail;

  always_comb begin
    off[0] = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      off[i+1] = off[i] + PW'(enq_mask_i[i]);
      waddr[i] = tail_q[AW-1:0] + off[i][AW-1:0];
      spc[i]   = (enq_pc_i & ~PCM)
               | ((enq_pc_i + 32'(4 * i)) & PCM);
    end
  end

  always_comb begin
    head_d = head_q + deq_n;
    tail_d = accept ? tail_q + off[FETCH_W] : tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (enq_mask_i[i]) begin
          data_q[waddr[i]] <= enq_data_i[i*ENTRY_W +: ENTRY_W];
          pc_q[waddr[i]]   <= spc[i];
        end
      end
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_rd
    logic [AW-1:0] raddr;
    assign raddr = head_q[AW-1:0] + AW'(k);
    assign out_valid_o[k] = (count > PW'(k));
    assign out_pc_o[k*32 +: 32] = pc_q[raddr];
    assign out_data_o[k*ENTRY_W +: ENTRY_W] = data_q[raddr];
  end

endmodule

// File: tb/tb_inst_queue_param.sv
// Scoreboard bench for inst_queue_param: the driver predicts each cycle's
// outputs from a queue model, a monitor pops and compares them.
module tb_inst_queue_param;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush_i = 1'b0;
  logic         enq_valid_i = 1'b0;
  logic         enq_ready_o;
  logic [3:0]   enq_mask_i = '0;
  logic [31:0]  enq_pc_i = '0;
  logic [287:0] enq_data_i = '0;
  logic [1:0]   deq_num_i = '0;
  logic [1:0]   out_valid_o;
  logic [63:0]  out_pc_o;
  logic [143:0] out_data_o;
  logic [4:0]   count_o;
  logic         empty_o;
  logic         full_o;
  logic         stop_fetch_o;
  logic         drop_err_o;

  inst_queue_param dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .enq_valid_i  (enq_valid_i),
    .enq_ready_o  (enq_ready_o),
    .enq_mask_i   (enq_mask_i),
    .enq_pc_i     (enq_pc_i),
    .enq_data_i   (enq_data_i),
    .deq_num_i    (deq_num_i),
    .out_valid_o  (out_valid_o),
    .out_pc_o     (out_pc_o),
    .out_data_o   (out_data_o),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .stop_fetch_o (stop_fetch_o),
    .drop_err_o   (drop_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [71:0] d;
  } ent_t;

  typedef struct {
    int   cnt;
    bit   rdy, emp, ful, stp, drp;
    bit   [1:0] vld;
    ent_t e0, e1;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    n_tot++;
    if (a !== e)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    else
      n_pass++;
  endtask

  function automatic logic [71:0] rnd72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  // One cycle: drive inputs, predict outputs, advance the model.
  task automatic cyc(bit r, bit fl, bit ev, logic [3:0] m,
                     logic [31:0] pc, logic [1:0] dq);
    exp_t x;
    int sz, n;
    ent_t e;
    logic [1:0] sl;
    @(negedge clk);
    rst = r; flush_i = fl; enq_valid_i = ev;
    enq_mask_i = m; enq_pc_i = pc; deq_num_i = dq;
    for (int i = 0; i < 4; i++) enq_data_i[i*72 +: 72] = rnd72();
    sz = mq.size();
    x.cnt = sz;
    x.rdy = (16 - sz) >= 4;
    x.emp = (sz == 0);
    x.ful = (sz == 16);
    x.stp = (sz >= 11) && !fl;
    x.drp = ev && !x.rdy && !fl;
    x.vld = {sz > 1, sz > 0};
    x.e0 = (sz > 0) ? mq[0] : '0;
    x.e1 = (sz > 1) ? mq[1] : '0;
    exp_q.push_back(x);
    if (!r || fl) begin
      mq.delete();
    end else begin
      n = dq;
      if (n > sz) n = sz;
      if (n > 2) n = 2;
      repeat (n) void'(mq.pop_front());
      if (ev && x.rdy) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) begin
            sl = pc[3:2] + 2'(i);
            e.pc = {pc[31:4], sl, pc[1:0]};
            e.d = enq_data_i[i*72 +: 72];
            mq.push_back(e);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t r;
    #2;
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      chk("count", 128'(count_o), 128'(r.cnt));
      chk("ready", 128'(enq_ready_o), 128'(r.rdy));
      chk("empty", 128'(empty_o), 128'(r.emp));
      chk("full", 128'(full_o), 128'(r.ful));
      chk("stop_fetch", 128'(stop_fetch_o), 128'(r.stp));
      chk("drop_err", 128'(drop_err_o), 128'(r.drp));
      chk("out_valid", 128'(out_valid_o), 128'(r.vld));
      if (r.vld[0]) begin
        chk("pc0", 128'(out_pc_o[31:0]), 128'(r.e0.pc));
        chk("data0", 128'(out_data_o[71:0]), 128'(r.e0.d));
      end
      if (r.vld[1]) begin
        chk("pc1", 128'(out_pc_o[63:32]), 128'(r.e1.pc));
        chk("data1", 128'(out_data_o[143:72]), 128'(r.e1.d));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    mq.delete();
    // basic full packet, then flush
    cyc(1, 0, 1, 4'b1111, 32'h1000, 0);
    cyc(1, 0, 0, 4'b0000, 32'h0, 0);
    cyc(1, 1, 0, 4'b0000, 32'h0, 0);
    // sparse mask with in-block PC wrap
    cyc(1, 0, 1, 4'b1010, 32'hBFC0_0008, 0);
    cyc(1, 0, 0, 4'b0000, 32'h0, 0);
    cyc(1, 0, 1, 4'b0000, 32'h2000, 1);
    cyc(1, 1, 0, 4'b0000, 32'h0, 0);
    // fill past the ready limit, drop, drain, then reach full
    cyc(1, 0, 1, 4'b1111, 32'h3000, 0);
    cyc(1, 0, 1, 4'b1111, 32'h3010, 0);
    cyc(1, 0, 1, 4'b1111, 32'h3020, 0);
    cyc(1, 0, 1, 4'b0001, 32'h3030, 0);
    cyc(1, 0, 1, 4'b1111, 32'h3040, 0);
    cyc(1, 0, 0, 4'b0000, 32'h0, 2);
    cyc(1, 0, 1, 4'b1111, 32'h3050, 0);
    cyc(1, 0, 1, 4'b1111, 32'h3060, 2);
    cyc(1, 0, 0, 4'b0000, 32'h0, 1);
    cyc(1, 0, 1, 4'b1111, 32'h3070, 0);
    cyc(1, 0, 1, 4'b1111, 32'h3080, 0);
    repeat (9) cyc(1, 0, 0, 4'b0000, 32'h0, 2);
    // single entry with over-request
    cyc(1, 0, 1, 4'b0100, 32'h4000, 0);
    cyc(1, 0, 0, 4'b0000, 32'h0, 2);
    cyc(1, 0, 0, 4'b0000, 32'h0, 3);
    // flush with simultaneous enqueue and dequeue
    cyc(1, 0, 1, 4'b1111, 32'h5000, 0);
    cyc(1, 0, 1, 4'b0111, 32'h5010, 0);
    cyc(1, 1, 1, 4'b1111, 32'h5020, 2);
    cyc(1, 0, 0, 4'b0000, 32'h0, 0);
    // steady stream through pointer wrap
    for (int i = 0; i < 40; i++)
      cyc(1, 0, 1, 4'b1111, 32'h6000 + 32'(i * 16), 2);
    // reset mid-traffic
    cyc(0, 0, 1, 4'b1111, 32'h7000, 1);
    cyc(1, 0, 0, 4'b0000, 32'h0, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(63) != 0, $urandom_range(31) == 0,
          $urandom_range(3) != 0, 4'($urandom),
          $urandom, 2'($urandom));
    @(negedge clk);
    #5;
    n_tot++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
